// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: in-order writeback FIFO draining into the register file, with RAW hazard lookup.
// Optional macro WB_FWD_EN builds youngest-match forwarding of queued data to decode.
module regfile_writeback_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_stall,
    output logic                    o_we,
    output logic [ADDR_WIDTH-1:0]   o_rd_addr,
    output logic [DATA_WIDTH-1:0]   o_rd,
    input  logic [ADDR_WIDTH-1:0]   i_rs1_addr,
    input  logic [ADDR_WIDTH-1:0]   i_rs2_addr,
    output logic                    o_rs1_pending,
    output logic                    o_rs2_pending,
    output logic [DATA_WIDTH-1:0]   o_rs1_fwd,
    output logic [DATA_WIDTH-1:0]   o_rs2_fwd,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int PW = $clog2(DEPTH);
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      valid;
    logic [PW-1:0]         head, tail;
    logic [PW:0]           count;
    logic                  push, pop, busy;
    assign busy      = count != '0;
    assign o_ready   = count < (PW+1)'(DEPTH);
    // x0 writes complete the handshake but are never queued
    assign push      = i_valid && o_ready && (i_addr != '0);
    assign o_we      = busy && !i_stall;
    assign pop       = o_we;
    assign o_rd_addr = busy ? addr_q[head] : '0;
    assign o_rd      = busy ? data_q[head] : '0;
    assign o_count   = count;
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (push) begin
                addr_q[tail] <= i_addr;
                data_q[tail] <= i_data;
                valid[tail]  <= 1'b1;
                tail         <= tail + 1'b1;
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    always_comb begin
        o_rs1_pending = 1'b0;
        o_rs2_pending = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            o_rs1_pending = o_rs1_pending | (valid[k] && (addr_q[k] == i_rs1_addr));
            o_rs2_pending = o_rs2_pending | (valid[k] && (addr_q[k] == i_rs2_addr));
        end
        o_rs1_pending = o_rs1_pending && (i_rs1_addr != '0);
        o_rs2_pending = o_rs2_pending && (i_rs2_addr != '0);
    end
`ifdef WB_FWD_EN
    logic [PW-1:0] idx;
    // walk oldest to youngest so the last match (closest to tail) wins
    always_comb begin
        o_rs1_fwd = '0;
        o_rs2_fwd = '0;
        idx       = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (valid[idx] && (addr_q[idx] == i_rs1_addr) && (i_rs1_addr != '0)) o_rs1_fwd = data_q[idx];
            if (valid[idx] && (addr_q[idx] == i_rs2_addr) && (i_rs2_addr != '0)) o_rs2_fwd = data_q[idx];
        end
    end
`else
    assign o_rs1_fwd = '0;
    assign o_rs2_fwd = '0;
`endif
endmodule
